hat_lfsr_source: RTL and testbench

//  Four-lane uniform sample source feeding the multihat adder stage (in0..in3).
//  - Each lane is a 32-bit Galois LFSR, leaped LEAP steps per cycle.
//  - Each lane emits one 16-bit two's-complement uniform "hat" sample per cycle while running.
//  - Provides seed loading, a warm-up phase and start/stop control, so the downstream sum sees decorrelated lanes.

---
 rtl/hat_pkg.sv | 33 +++
 rtl/galois_leap.sv | 19 +
 rtl/hat_lfsr_source.sv | 119 +++++++++++
 tb/tb_hat_lfsr_source.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hat_pkg.sv
// Shared constants, state encoding and LFSR step helper for the four-lane hat sample source.
package hat_pkg;
    localparam int LANES  = 4;
    localparam int LFSR_W = 32;
    localparam int OUT_W  = 16;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } hat_state_t;

    function automatic logic [LFSR_W-1:0] default_seed(input int lane);
        logic [LFSR_W-1:0] s;
        case (lane)
            0:       s = 32'hACE1_2468;
            1:       s = 32'h1357_BDF0;
            2:       s = 32'hDEAD_BEEF;
            default: s = 32'h0BAD_F00D;
        endcase
        return s;
    endfunction

    function automatic logic [LFSR_W-1:0] galois_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ LFSR_POLY;
        return n;
    endfunction
endpackage

// File: rtl/galois_leap.sv
// Combinational LEAP-step Galois LFSR advance for one lane; zero latency, no flow control.
module galois_leap
    import hat_pkg::*;
#(
    parameter int LEAP = 16
) (
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] state_o
);
    logic [LFSR_W-1:0] s;

    always_comb begin
        s = state_i;
        for (int k = 0; k < LEAP; k++) begin
            s = galois_step(s);
        end
        state_o = s;
    end
endmodule

// File: rtl/hat_lfsr_source.sv
// Four-lane leaped-LFSR uniform sample source with seed load, warm-up and start/stop control.
// First sample registered WARMUP+1 edges after start is sampled; no backpressure, out_valid only qualifies.
module hat_lfsr_source
    import hat_pkg::*;
#(
    parameter int LEAP   = 16,
    parameter int WARMUP = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    seed_valid,
    input  logic [1:0]              seed_lane,
    input  logic [LFSR_W-1:0]       seed_data,
    output logic                    seed_ready,
    input  logic                    start,
    input  logic                    stop,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out0,
    output logic signed [OUT_W-1:0] out1,
    output logic signed [OUT_W-1:0] out2,
    output logic signed [OUT_W-1:0] out3
);
    localparam int CNT_W = $clog2(WARMUP + 1);

    hat_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LFSR_W-1:0]       lane_q [LANES];
    logic [LFSR_W-1:0]       lane_d [LANES];
    logic [LFSR_W-1:0]       lane_nxt [LANES];
    logic signed [OUT_W-1:0] out_q [LANES];
    logic signed [OUT_W-1:0] out_d [LANES];
    logic                    out_vld_q, out_vld_d;
    logic                    advance;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        galois_leap #(.LEAP(LEAP)) u_leap (
            .state_i (lane_q[g]),
            .state_o (lane_nxt[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_vld_d = 1'b0;
        advance   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = lane_q[i];
            out_d[i]  = '0;
        end

        case (state_q)
            ST_IDLE: begin
                // a seed written on the start edge is what the warm-up runs from
                if (seed_valid) begin
                    lane_d[seed_lane] = (seed_data == '0) ? LFSR_W'(1) : seed_data;
                end
                if (start && !stop) begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    advance = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WARMUP - 1)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    advance   = 1'b1;
                    out_vld_d = 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        out_d[i] = lane_q[i][LFSR_W-1 -: OUT_W];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            for (int i = 0; i < LANES; i++) lane_d[i] = lane_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= default_seed(i);
                out_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
                out_q[i]  <= out_d[i];
            end
        end
    end

    assign seed_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_vld_q;
    assign out0       = out_q[0];
    assign out1       = out_q[1];
    assign out2       = out_q[2];
    assign out3       = out_q[3];
endmodule

// File: tb/tb_hat_lfsr_source.sv
// Randomized scoreboard bench: expected sample bursts are queued at start time and popped by a monitor on out_valid.
module tb_hat_lfsr_source;
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               seed_valid = 1'b0;
    logic [1:0]         seed_lane = 2'd0;
    logic [31:0]        seed_data = 32'd0;
    logic               seed_ready;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               busy;
    logic               out_valid;
    logic signed [15:0] out0, out1, out2, out3;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    logic [31:0] model [4];
    logic [63:0] exp_q [$];

    hat_lfsr_source dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seed_valid (seed_valid),
        .seed_lane  (seed_lane),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .out_valid  (out_valid),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: polynomial x^32+x^22+x^2+x+1, sixteen shift-right steps per sample slot
    function automatic logic [31:0] ref_leap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        repeat (16) begin
            if (r[0]) r = (r >> 1) ^ 32'h8020_0003;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic void model_defaults();
        model[0] = 32'hACE1_2468;
        model[1] = 32'h1357_BDF0;
        model[2] = 32'hDEAD_BEEF;
        model[3] = 32'h0BAD_F00D;
    endfunction

    function automatic void model_seed(input int lane, input logic [31:0] d);
        model[lane] = (d == 32'd0) ? 32'd1 : d;
    endfunction

    // A burst of r samples: 64 warm-up leaps, then each sample is the pre-leap state's top half
    function automatic void model_burst(input int r);
        repeat (64) for (int l = 0; l < 4; l++) model[l] = ref_leap(model[l]);
        for (int n = 0; n < r; n++) begin
            exp_q.push_back({model[3][31:16], model[2][31:16], model[1][31:16], model[0][31:16]});
            for (int l = 0; l < 4; l++) model[l] = ref_leap(model[l]);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_sample", {out3, out2, out1, out0}, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk({out3, out2, out1, out0} == e, "sample", {out3, out2, out1, out0}, e);
                end
            end else begin
                chk({out3, out2, out1, out0} == 64'd0, "idle_outs_zero", {out3, out2, out1, out0}, 64'd0);
            end
        end
    end

    task automatic write_seed(input int lane, input logic [31:0] d);
        seed_valid = 1'b1;
        seed_lane  = 2'(lane);
        seed_data  = d;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        model_seed(lane, d);
    endtask

    task automatic burst(input int r, input bit inj, input bit seed_with_start,
                         input int sl, input logic [31:0] sd);
        int first;
        first = 0;
        if (seed_with_start) begin
            seed_valid = 1'b1;
            seed_lane  = 2'(sl);
            seed_data  = sd;
            model_seed(sl, sd);
        end
        model_burst(r);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed_valid = 1'b0;
        for (int i = 1; i <= 64 + r; i++) begin
            @(posedge clk); #1;
            seed_valid = 1'b0;
            if (first == 0 && out_valid) first = i;
            if (i == 1) chk(busy && !seed_ready, "busy_in_warmup", {62'd0, busy, seed_ready}, 64'd2);
            if (inj && i == 66) begin
                seed_valid = 1'b1;
                seed_lane  = 2'($urandom_range(0, 3));
                seed_data  = $urandom;
            end
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk(!out_valid && !busy && seed_ready && {out3, out2, out1, out0} == 64'd0, "stop_clear",
            {out3, out2, out1, out0} ^ {61'd0, out_valid, busy, !seed_ready}, 64'd0);
        if (r > 0) chk(first == 65, "first_valid_edge", 64'(first), 64'd65);
        chk(exp_q.size() == 0, "samples_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        longint sum;
        int cnt;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk(!out_valid && !busy && seed_ready && {out3, out2, out1, out0} == 64'd0, "reset_state",
            {out3, out2, out1, out0} ^ {61'd0, out_valid, busy, !seed_ready}, 64'd0);
        reset_n = 1'b1;
        model_defaults();
        mon_en = 1'b1;
        @(posedge clk); #1;
        burst(20, 1'b0, 1'b0, 0, 32'd0);

        // zero seed lands as 1
        write_seed(2, 32'd0);
        burst(30, 1'b0, 1'b0, 0, 32'd0);

        // seeds 1..4, long run
        for (int l = 0; l < 4; l++) write_seed(l, 32'(l + 1));
        burst(1000, 1'b0, 1'b0, 0, 32'd0);

        // stop after 10 then resume from held state
        burst(10, 1'b0, 1'b0, 0, 32'd0);
        burst(15, 1'b0, 1'b0, 0, 32'd0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
        chk(!busy && seed_ready, "start_stop_idle", {62'd0, busy, seed_ready}, 64'd1);

        // seed write during RUN is ignored
        burst(40, 1'b1, 1'b0, 0, 32'd0);

        // randomized seeds and lengths, including seed on the start edge
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) write_seed(l, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
            burst($urandom_range(12, 60), k[0], k[1], $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
        end

        // async reset in the middle of RUN
        mon_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (69) @(posedge clk);
        #3;
        chk(out_valid, "valid_before_reset", {63'd0, out_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk(!out_valid && !busy && seed_ready && {out3, out2, out1, out0} == 64'd0, "async_reset_clear",
            {out3, out2, out1, out0} ^ {61'd0, out_valid, busy, !seed_ready}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        model_defaults();
        mon_en = 1'b1;
        @(posedge clk); #1;
        burst(20, 1'b0, 1'b0, 0, 32'd0);

        // long-run mean across all four lanes
        mon_en = 1'b0;
        sum = 0;
        cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20064; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                sum += longint'(out0) + longint'(out1) + longint'(out2) + longint'(out3);
                cnt += 4;
            end
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk(cnt == 80000, "mean_sample_count", 64'(cnt), 64'd80000);
        if (cnt > 0) begin
            longint mean;
            mean = sum / cnt;
            chk(mean >= -400 && mean <= 400, "sample_mean", 64'(mean), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
